// File: rtl/vga_draw_pkg.sv
// Shared types and screen geometry for the VGA draw scheduler.
// Used by vga_draw_scheduler and draw_layer_select.
package vga_draw_pkg;

  localparam logic [8:0] SCREEN_W = 9'd320;
  localparam logic [7:0] SCREEN_H = 8'd240;

  typedef logic [8:0] xcoord_t;
  typedef logic [7:0] ycoord_t;
  typedef logic [2:0] color_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    GRANT   = 2'd2,
    ADVANCE = 2'd3
  } sched_state_t;

  function automatic logic on_screen(input xcoord_t px, input ycoord_t py);
    return (px < SCREEN_W) && (py < SCREEN_H);
  endfunction

endpackage

// File: rtl/draw_layer_select.sv
// Finds the lowest enabled layer strictly above the current index.
// A current index of -1 (all ones) searches from layer 0.
module draw_layer_select
  import vga_draw_pkg::*;
#(
  parameter int N_LAYERS = 3,
  parameter int IDX_W    = 2
) (
  input  logic [N_LAYERS-1:0] mask,
  input  logic signed [IDX_W:0] cur,
  output logic [IDX_W-1:0]    nxt,
  output logic                found
);

  // Downward scan so the lowest qualifying index is the one left standing.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        found = 1'b1;
        nxt   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/vga_draw_scheduler.sv
// Frame scheduler granting the VGA pixel-write port to draw layers in order.
// Optional build macro VGA_SCHED_OVERRUN_CNT_EN adds an ignored-V_SYNC counter port.
module vga_draw_scheduler
  import vga_draw_pkg::*;
#(
  parameter int N_LAYERS       = 3,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic                   clk,
  input  logic                   iResetn,
  input  logic                   iVSync,
  input  logic [N_LAYERS-1:0]    iLayerEn,
  input  xcoord_t [N_LAYERS-1:0] iReqX,
  input  ycoord_t [N_LAYERS-1:0] iReqY,
  input  color_t  [N_LAYERS-1:0] iReqColor,
  input  logic [N_LAYERS-1:0]    iReqValid,
  input  logic [N_LAYERS-1:0]    iReqDone,
  output logic [N_LAYERS-1:0]    oGrant,
  output logic [N_LAYERS-1:0]    oStart,
  output xcoord_t                x,
  output ycoord_t                y,
  output color_t                 color,
  output logic                   writeEn,
  output logic                   oBusy,
  output logic                   oFrameDone,
  output logic                   oTimeout
`ifdef VGA_SCHED_OVERRUN_CNT_EN
  ,
  output logic [7:0]             oOverrunCnt
`endif
);

  localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};

  sched_state_t         state_q, state_d;
  logic                 vsync_prev_q, vsync_prev_d;
  logic [N_LAYERS-1:0]  mask_q, mask_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [N_LAYERS-1:0]  grant_q, grant_d;
  logic [N_LAYERS-1:0]  start_q, start_d;
  xcoord_t              x_q, x_d;
  ycoord_t              y_q, y_d;
  color_t               color_q, color_d;
  logic                 we_q, we_d;
  logic                 busy_q, busy_d;
  logic                 fdone_q, fdone_d;
  logic                 timeout_q, timeout_d;
  logic [7:0]           ovr_q, ovr_d;

  logic                 fall_s;
  logic                 hit_wd_s;
  logic [N_LAYERS-1:0]  sel_mask_s;
  logic signed [IDX_W:0] sel_cur_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic                 sel_found_s;

  draw_layer_select #(
    .N_LAYERS (N_LAYERS),
    .IDX_W    (IDX_W)
  ) u_select (
    .mask  (sel_mask_s),
    .cur   (sel_cur_s),
    .nxt   (sel_idx_s),
    .found (sel_found_s)
  );

  // Selector sees the live enables in START (mask is latched that cycle).
  always_comb begin
    if (state_q == START) begin
      sel_mask_s = iLayerEn;
      sel_cur_s  = '1;
    end else begin
      sel_mask_s = mask_q;
      sel_cur_s  = $signed({1'b0, idx_q});
    end
  end

  // Next-state and registered-output computation for the frame sequencer.
  always_comb begin
    fall_s       = ~iVSync & vsync_prev_q;
    hit_wd_s     = (wd_q == WD_LAST);
    vsync_prev_d = iVSync;
    state_d      = state_q;
    mask_d       = mask_q;
    idx_d        = idx_q;
    wd_d         = wd_q;
    grant_d      = grant_q;
    start_d      = '0;
    x_d          = x_q;
    y_d          = y_q;
    color_d      = color_q;
    we_d         = 1'b0;
    busy_d       = busy_q;
    fdone_d      = 1'b0;
    timeout_d    = timeout_q;
    ovr_d        = ovr_q;

    if (fall_s && (state_q != IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end else begin
      ovr_d = ovr_q;
    end

    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (fall_s) begin
          state_d = START;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      START, ADVANCE: begin
        grant_d = '0;
        wd_d    = '0;
        if (state_q == START) begin
          mask_d = iLayerEn;
        end else begin
          mask_d = mask_q;
        end
        if (sel_found_s) begin
          state_d = GRANT;
          idx_d   = sel_idx_s;
          grant_d = N_LAYERS'(1) << sel_idx_s;
          start_d = N_LAYERS'(1) << sel_idx_s;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          fdone_d = 1'b1;
        end
      end
      GRANT: begin
        x_d     = iReqX[idx_q];
        y_d     = iReqY[idx_q];
        color_d = iReqColor[idx_q];
        we_d    = iReqValid[idx_q] & on_screen(iReqX[idx_q], iReqY[idx_q]);
        if (iReqDone[idx_q] || hit_wd_s) begin
          state_d = ADVANCE;
          grant_d = '0;
          wd_d    = '0;
          if (hit_wd_s) begin
            timeout_d = 1'b1;
          end else begin
            timeout_d = timeout_q;
          end
        end else begin
          wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops grant and strobe immediately.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state_q      <= IDLE;
      vsync_prev_q <= 1'b1;
      mask_q       <= '0;
      idx_q        <= '0;
      wd_q         <= '0;
      grant_q      <= '0;
      start_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      fdone_q      <= 1'b0;
      timeout_q    <= 1'b0;
      ovr_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      vsync_prev_q <= vsync_prev_d;
      mask_q       <= mask_d;
      idx_q        <= idx_d;
      wd_q         <= wd_d;
      grant_q      <= grant_d;
      start_q      <= start_d;
      x_q          <= x_d;
      y_q          <= y_d;
      color_q      <= color_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      fdone_q      <= fdone_d;
      timeout_q    <= timeout_d;
      ovr_q        <= ovr_d;
    end
  end

  assign oGrant     = grant_q;
  assign oStart     = start_q;
  assign x          = x_q;
  assign y          = y_q;
  assign color      = color_q;
  assign writeEn    = we_q;
  assign oBusy      = busy_q;
  assign oFrameDone = fdone_q;
  assign oTimeout   = timeout_q;

`ifdef VGA_SCHED_OVERRUN_CNT_EN
  assign oOverrunCnt = ovr_q;
`else
  logic unused_ovr_s;
  assign unused_ovr_s = ^ovr_q;
`endif

endmodule
